// File: rtl/hw_cipher_pkg.sv
// Purpose: shared constants, FSM encoding and key/permutation helpers for the Feistel cipher core.
// Latency: n/a (package only).
// Backpressure: n/a.
package hw_cipher_pkg;

  // Word addresses on the Avalon-MM slave
  localparam logic [3:0] ADDR_DATA0  = 4'd0;
  localparam logic [3:0] ADDR_DATA3  = 4'd3;
  localparam logic [3:0] ADDR_KEY0   = 4'd4;
  localparam logic [3:0] ADDR_KEY3   = 4'd7;
  localparam logic [3:0] ADDR_CTRL   = 4'd8;
  localparam logic [3:0] ADDR_STATUS = 4'd9;

  // CTRL / STATUS bit positions
  localparam int CTRL_START    = 0;
  localparam int CTRL_MODE     = 1;
  localparam int STATUS_BUSY   = 0;
  localparam int STATUS_DONE   = 1;
  localparam int STATUS_NR_LSB = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_KEXP,
    ST_RA,
    ST_RB,
    ST_RC_MIX,
    ST_DONE
  } fsm_e;

  // Round constants; only the low 7 bits matter since they are added mod 128.
  function automatic logic [6:0] rc_lookup(input logic [3:0] idx);
    logic [7:0] rc;
    case (idx)
      4'd0:    rc = 8'h5A;
      4'd1:    rc = 8'h34;
      4'd2:    rc = 8'h73;
      4'd3:    rc = 8'h66;
      4'd4:    rc = 8'h57;
      4'd5:    rc = 8'h35;
      4'd6:    rc = 8'h71;
      4'd7:    rc = 8'h62;
      4'd8:    rc = 8'h5F;
      4'd9:    rc = 8'h25;
      4'd10:   rc = 8'h51;
      4'd11:   rc = 8'h22;
      default: rc = 8'h00;
    endcase
    return rc[6:0];
  endfunction

  // Swaps the 16-bit halves inside each 32-bit word; it is its own inverse.
  function automatic logic [63:0] perm(input logic [63:0] x);
    return {x[47:32], x[63:48], x[15:0], x[31:16]};
  endfunction

  function automatic logic [127:0] ks(input logic [127:0] k);
    logic [63:0] t;
    t = perm(k[63:0]);
    return {t, t ^ k[127:64]};
  endfunction

  // Exact inverse of ks(); relies on perm() being an involution.
  function automatic logic [127:0] ks_inv(input logic [127:0] k);
    return {k[63:0] ^ k[127:64], perm(k[127:64])};
  endfunction

  function automatic logic [63:0] rotl64(input logic [63:0] x, input int amt);
    return (x << amt) | (x >> (64 - amt));
  endfunction

endpackage

// File: rtl/hw_cipher_round.sv
// Purpose: sbox input word pair (h) and F-assembly + Feistel mix from latched sbox outputs.
// Latency: combinational.
// Backpressure: none.
// Ports: state/key (128) in, s_hi/s_lo (32) latched sbox outputs, rnd (4) round index,
//        mode (0=enc,1=dec); h (64) pre-sbox value, next_state (128) mixed state.
module hw_cipher_round
  import hw_cipher_pkg::*;
#(
  parameter int ROT = 21
) (
  input  logic [127:0] state,
  input  logic [127:0] key,
  input  logic [31:0]  s_hi,
  input  logic [31:0]  s_lo,
  input  logic [3:0]   rnd,
  input  logic         mode,
  output logic [63:0]  h,
  output logic [127:0] next_state
);

  logic [63:0] x;
  logic [63:0] y;
  logic [63:0] f;

  // Encrypt feeds F from H, decrypt from L.
  assign x = mode ? state[63:0] : state[127:64];
  assign h = x ^ key[127:64];

  always_comb begin
    y          = {s_hi, s_lo};
    y[20:14]   = y[20:14] + rc_lookup(rnd);
    y          = y ^ key[63:0];
    f          = rotl64(perm(y), ROT);
    next_state = mode ? {state[63:0], state[127:64] ^ f}
                      : {state[63:0] ^ f, state[127:64]};
  end

endmodule

// File: rtl/sbox.sv
// Purpose: shared 32-bit combinational sbox, eight parallel 4-bit substitutions.
// Latency: combinational.
// Backpressure: none.
// Ports: din (32) in, dout (32) out.
module sbox (
  input  logic [31:0] din,
  output logic [31:0] dout
);

  function automatic logic [3:0] sb4(input logic [3:0] n);
    case (n)
      4'h0: return 4'hC;
      4'h1: return 4'h5;
      4'h2: return 4'h6;
      4'h3: return 4'hB;
      4'h4: return 4'h9;
      4'h5: return 4'h0;
      4'h6: return 4'hA;
      4'h7: return 4'hD;
      4'h8: return 4'h3;
      4'h9: return 4'hE;
      4'hA: return 4'hF;
      4'hB: return 4'h8;
      4'hC: return 4'h4;
      4'hD: return 4'h7;
      4'hE: return 4'h1;
      default: return 4'h2;
    endcase
  endfunction

  always_comb begin
    dout = '0;
    for (int i = 0; i < 8; i++) begin
      dout[4*i +: 4] = sb4(din[4*i +: 4]);
    end
  end

endmodule

// File: rtl/hw_cipher_engine.sv
// Purpose: iterative 128-bit Feistel cipher behind a 32-bit Avalon-MM slave (DATA/KEY/CTRL/STATUS).
// Latency: START to BUSY low = 3R+1 cycles encrypt, 4R+1 cycles decrypt.
// Backpressure: waitrequest stalls any access to words 0-8 while BUSY; STATUS never stalls.
// Ports: clk, reset (sync, active-high), address (4), write, writedata (32), read,
//        readdata (32, combinational, 0 when read low), waitrequest.
module hw_cipher_engine
  import hw_cipher_pkg::*;
#(
  parameter int NUM_ROUNDS = 12,
  parameter int ROT        = 21
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  address,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic        read,
  output logic [31:0] readdata,
  output logic        waitrequest
);

  localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS - 1);
  localparam logic [3:0] NR_FIELD = 4'(NUM_ROUNDS);

  logic [127:0] data_q;
  logic [127:0] key_q;
  logic [127:0] st_q;
  logic [127:0] kw_q;
  logic [31:0]  s_hi_q;
  logic [31:0]  s_lo_q;
  logic [3:0]   rnd_q;
  logic [3:0]   kcnt_q;
  logic         mode_q;
  logic         busy_q;
  logic         done_q;
  fsm_e         fsm_q;

  logic         wr_ok;
  logic [127:0] key_eff;
  logic [63:0]  h;
  logic [127:0] next_st;
  logic [31:0]  sbox_in;
  logic [31:0]  sbox_out;

  assign waitrequest = (read | write) && (address <= ADDR_CTRL) && busy_q;
  assign wr_ok       = write && !waitrequest;

  // Encrypt steps the key in RA and that new key is already needed for the
  // high-word sbox lookup of the same cycle.
  assign key_eff = (fsm_q == ST_RA && !mode_q) ? ks(kw_q) : kw_q;

  assign sbox_in = (fsm_q == ST_RA) ? h[63:32] : h[31:0];

  sbox u_sbox (
    .din  (sbox_in),
    .dout (sbox_out)
  );

  hw_cipher_round #(
    .ROT (ROT)
  ) u_round (
    .state      (st_q),
    .key        (key_eff),
    .s_hi       (s_hi_q),
    .s_lo       (s_lo_q),
    .rnd        (rnd_q),
    .mode       (mode_q),
    .h          (h),
    .next_state (next_st)
  );

  always_comb begin
    readdata = '0;
    if (read) begin
      if (address <= ADDR_DATA3) begin
        readdata = data_q[{address[1:0], 5'b0} +: 32];
      end else if (address == ADDR_STATUS) begin
        readdata[STATUS_BUSY] = busy_q;
        readdata[STATUS_DONE] = done_q;
        readdata[STATUS_NR_LSB +: 4] = NR_FIELD;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
      key_q  <= '0;
      st_q   <= '0;
      kw_q   <= '0;
      s_hi_q <= '0;
      s_lo_q <= '0;
      rnd_q  <= '0;
      kcnt_q <= '0;
      mode_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      fsm_q  <= ST_IDLE;
    end else begin
      // Register writes can only land while idle since waitrequest holds them off otherwise.
      if (wr_ok && address <= ADDR_DATA3) begin
        data_q[{address[1:0], 5'b0} +: 32] <= writedata;
        done_q <= 1'b0;
      end
      if (wr_ok && address >= ADDR_KEY0 && address <= ADDR_KEY3) begin
        key_q[{address[1:0], 5'b0} +: 32] <= writedata;
      end

      case (fsm_q)
        ST_IDLE: begin
          if (wr_ok && address == ADDR_CTRL && writedata[CTRL_START]) begin
            st_q   <= data_q;
            kw_q   <= key_q;
            mode_q <= writedata[CTRL_MODE];
            busy_q <= 1'b1;
            done_q <= 1'b0;
            kcnt_q <= '0;
            rnd_q  <= writedata[CTRL_MODE] ? LAST_RND : 4'd0;
            fsm_q  <= writedata[CTRL_MODE] ? ST_KEXP : ST_RA;
          end
        end
        ST_KEXP: begin
          // Run the schedule forward to the last round key; decrypt walks it back.
          kw_q   <= ks(kw_q);
          kcnt_q <= kcnt_q + 4'd1;
          if (kcnt_q == LAST_RND) begin
            fsm_q <= ST_RA;
          end
        end
        ST_RA: begin
          kw_q   <= key_eff;
          s_hi_q <= sbox_out;
          fsm_q  <= ST_RB;
        end
        ST_RB: begin
          s_lo_q <= sbox_out;
          fsm_q  <= ST_RC_MIX;
        end
        ST_RC_MIX: begin
          st_q <= next_st;
          if (mode_q) begin
            kw_q <= ks_inv(kw_q);
          end
          if (mode_q ? (rnd_q == 4'd0) : (rnd_q == LAST_RND)) begin
            fsm_q <= ST_DONE;
          end else begin
            rnd_q <= mode_q ? rnd_q - 4'd1 : rnd_q + 4'd1;
            fsm_q <= ST_RA;
          end
        end
        ST_DONE: begin
          data_q <= st_q;
          busy_q <= 1'b0;
          done_q <= 1'b1;
          fsm_q  <= ST_IDLE;
        end
        default: fsm_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hw_cipher_engine.sv
// Purpose: directed bench for hw_cipher_engine (R=12/ROT=21 and R=1/ROT=7 instances).
// Latency: checks exact START-to-idle and stall cycle counts.
// Backpressure: exercises waitrequest on accesses issued while busy.
module tb_hw_cipher_engine;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  address [2];
  logic        write [2];
  logic [31:0] writedata [2];
  logic        read [2];
  logic [31:0] readdata [2];
  logic        waitrequest [2];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hw_cipher_engine #(.NUM_ROUNDS(12), .ROT(21)) u_dut0 (
    .clk         (clk),
    .reset       (reset),
    .address     (address[0]),
    .write       (write[0]),
    .writedata   (writedata[0]),
    .read        (read[0]),
    .readdata    (readdata[0]),
    .waitrequest (waitrequest[0])
  );

  hw_cipher_engine #(.NUM_ROUNDS(1), .ROT(7)) u_dut1 (
    .clk         (clk),
    .reset       (reset),
    .address     (address[1]),
    .write       (write[1]),
    .writedata   (writedata[1]),
    .read        (read[1]),
    .readdata    (readdata[1]),
    .waitrequest (waitrequest[1])
  );

  // ---------------- reference model ----------------
  localparam logic [3:0] SB_TAB [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                         4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
  localparam logic [7:0] RC_TAB [12] = '{8'h5A, 8'h34, 8'h73, 8'h66, 8'h57, 8'h35,
                                         8'h71, 8'h62, 8'h5F, 8'h25, 8'h51, 8'h22};

  function automatic logic [31:0] m_sbox(input logic [31:0] w);
    logic [31:0] o;
    logic [3:0]  nib;
    for (int i = 0; i < 8; i++) begin
      nib = w[4*i +: 4];
      o[4*i +: 4] = SB_TAB[nib];
    end
    return o;
  endfunction

  function automatic logic [63:0] m_p(input logic [63:0] x);
    logic [15:0] a, b, c, d;
    {a, b, c, d} = x;
    return {b, a, d, c};
  endfunction

  function automatic logic [63:0] m_rotl(input logic [63:0] x, input int rot);
    logic [63:0] o;
    for (int i = 0; i < 64; i++) o[(i + rot) % 64] = x[i];
    return o;
  endfunction

  function automatic logic [127:0] m_encrypt(input logic [127:0] pt, input logic [127:0] key,
                                            input int nr, input int rot);
    logic [127:0] k;
    logic [63:0]  hh, ll, hx, y, f, t;
    logic [7:0]   rcv;
    k  = key;
    hh = pt[127:64];
    ll = pt[63:0];
    for (int r = 0; r < nr; r++) begin
      t  = m_p(k[63:0]);
      k  = {t, t ^ k[127:64]};
      hx = hh ^ k[127:64];
      y  = {m_sbox(hx[63:32]), m_sbox(hx[31:0])};
      rcv = RC_TAB[r];
      y[20:14] = y[20:14] + rcv[6:0];
      y  = y ^ k[63:0];
      f  = m_rotl(m_p(y), rot);
      t  = ll ^ f;
      ll = hh;
      hh = t;
    end
    return {hh, ll};
  endfunction

  // ---------------- checking ----------------
  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- bus tasks ----------------
  task automatic bus_write(input int u, input logic [3:0] a, input logic [31:0] d,
                           output int stalls);
    @(negedge clk);
    address[u] = a; writedata[u] = d; write[u] = 1'b1; stalls = 0;
    #1;
    while (waitrequest[u] && stalls < 2000) begin
      @(negedge clk); #1; stalls++;
    end
    @(posedge clk); #1;
    write[u] = 1'b0;
  endtask

  task automatic bus_read(input int u, input logic [3:0] a, output logic [31:0] d,
                          output int stalls);
    @(negedge clk);
    address[u] = a; read[u] = 1'b1; stalls = 0;
    #1;
    while (waitrequest[u] && stalls < 2000) begin
      @(negedge clk); #1; stalls++;
    end
    d = readdata[u];
    @(posedge clk); #1;
    read[u] = 1'b0;
  endtask

  task automatic load(input int u, input logic [127:0] pt, input logic [127:0] key);
    int s;
    for (int i = 0; i < 4; i++) bus_write(u, 4'(i), pt[32*i +: 32], s);
    for (int i = 0; i < 4; i++) bus_write(u, 4'(4 + i), key[32*i +: 32], s);
  endtask

  task automatic read_data(input int u, output logic [127:0] d);
    int s;
    logic [31:0] w;
    for (int i = 0; i < 4; i++) begin
      bus_read(u, 4'(i), w, s);
      d[32*i +: 32] = w;
    end
  endtask

  // Returns clock edges from the START-accepting edge until STATUS shows idle.
  task automatic start_op(input int u, input logic [31:0] ctrl, output int lat);
    int s;
    bus_write(u, 4'd8, ctrl, s);
    address[u] = 4'd9; read[u] = 1'b1; lat = 0;
    do begin
      @(posedge clk); lat++; #1;
    end while (readdata[u][0] && lat < 2000);
    read[u] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [127:0] pt_a, key_a, ct_a, pt_b, key_b, ct_b, d;
    logic [31:0]  w;
    int           s, lat;

    for (int u = 0; u < 2; u++) begin
      address[u] = '0; write[u] = 1'b0; writedata[u] = '0; read[u] = 1'b0;
    end
    pt_a  = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    key_a = 128'h00010203_04050607_08090A0B_0C0D0E0F;
    ct_a  = m_encrypt(pt_a, key_a, 12, 21);
    pt_b  = 128'hFEDCBA98_76543210_0F1E2D3C_4B5A6978;
    key_b = 128'h13579BDF_02468ACE_F0E1D2C3_B4A59687;
    ct_b  = m_encrypt(pt_b, key_b, 1, 7);

    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;

    // Reset state
    #1 check_val("readdata_idle", readdata[0], 0);
    bus_read(0, 4'd0, w, s);  check_val("rst_data0", w, 0); check_val("rst_wait", s, 0);
    bus_read(0, 4'd4, w, s);  check_val("rst_key0", w, 0);
    bus_read(0, 4'd9, w, s);  check_val("rst_status", w, 32'h0000_0C00);
    bus_read(0, 4'hF, w, s);  check_val("rst_unmapped", w, 0);

    // Encrypt, then decrypt back
    load(0, pt_a, key_a);
    start_op(0, 32'h1, lat);  check_val("enc_latency", lat, 37);
    read_data(0, d);          check_val("enc_result", d, ct_a);
    bus_read(0, 4'd9, w, s);  check_val("enc_status", w, 32'h0000_0C02);
    start_op(0, 32'h3, lat);  check_val("dec_latency", lat, 49);
    read_data(0, d);          check_val("dec_result", d, pt_a);

    // DATA write while busy stalls until the cycle after BUSY falls
    bus_write(0, 4'd8, 32'h1, s);
    bus_write(0, 4'd0, 32'hDEADBEEF, s);
    check_val("stall_cycles", s, 37);
    bus_read(0, 4'd9, w, s);  check_val("stall_status", w, 32'h0000_0C00);
    read_data(0, d);          check_val("stall_data", d, {ct_a[127:32], 32'hDEADBEEF});

    // Reset mid-operation
    load(0, pt_a, key_a);
    bus_write(0, 4'd8, 32'h1, s);
    repeat (10) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    bus_read(0, 4'd9, w, s);  check_val("abort_status", w, 32'h0000_0C00);
    read_data(0, d);          check_val("abort_data", d, 0);
    load(0, pt_a, key_a);
    start_op(0, 32'h1, lat);  check_val("rerun_latency", lat, 37);
    read_data(0, d);          check_val("rerun_result", d, ct_a);

    // STATUS write ignored, KEY reads zero, repeated STARTs consistent
    bus_write(0, 4'd9, 32'hFFFF_FFFF, s);
    bus_read(0, 4'd9, w, s);  check_val("status_ro", w, 32'h0000_0C02);
    bus_read(0, 4'd6, w, s);  check_val("key2_wo", w, 0);
    start_op(0, 32'h1, lat);
    read_data(0, d);          check_val("enc_of_ct", d, m_encrypt(ct_a, key_a, 12, 21));
    for (int i = 0; i < 4; i++) bus_write(0, 4'(i), pt_a[32*i +: 32], s);
    start_op(0, 32'h1, lat);
    read_data(0, d);          check_val("b2b_first", d, ct_a);
    for (int i = 0; i < 4; i++) bus_write(0, 4'(i), pt_a[32*i +: 32], s);
    start_op(0, 32'h1, lat);
    read_data(0, d);          check_val("b2b_second", d, ct_a);

    // Single-round instance
    bus_read(1, 4'd9, w, s);  check_val("r1_status", w, 32'h0000_0100);
    load(1, pt_b, key_b);
    start_op(1, 32'h1, lat);  check_val("r1_enc_latency", lat, 4);
    read_data(1, d);          check_val("r1_enc_result", d, ct_b);
    start_op(1, 32'h3, lat);  check_val("r1_dec_latency", lat, 5);
    read_data(1, d);          check_val("r1_dec_result", d, pt_b);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
